// File: rtl/meas_scheduler.sv
// Measurement scheduler: frames a counting gate on 5 ms timebase ticks,
// then requests a host readout with an acknowledge timeout.
module meas_scheduler #(
    parameter int unsigned PERIOD_W    = 8,
    parameter logic [15:0] ACK_TIMEOUT = 16'd40000
) (
    input  logic                clk_4mhz,
    input  logic                reset_n,
    input  logic                clk_5ms,
    input  logic                start,
    input  logic                stop,
    input  logic [PERIOD_W-1:0] cfg_ticks,
    input  logic                rd_ack,
    output logic                gate,
    output logic                rd_req,
    output logic                busy,
    output logic [15:0]         frame_cnt,
    output logic                overrun
);

    localparam int unsigned TO_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_ACQ  = 2'd2,
        S_READ = 2'd3
    } state_t;

    state_t              state, state_n;
    logic [PERIOD_W-1:0] tick_left, tick_left_n;
    logic [15:0]         frame_cnt_n;
    logic                stop_pend, stop_pend_n;
    logic                overrun_n;
    logic [TO_W-1:0]     to_cnt, to_cnt_n;
    logic                c5_q;
    logic                tick_en;

    // Rising-edge detect of the timebase square wave, one-cycle registered pulse
    always_ff @(posedge clk_4mhz or negedge reset_n) begin
        if (!reset_n) begin
            c5_q    <= 1'b0;
            tick_en <= 1'b0;
        end else begin
            c5_q    <= clk_5ms;
            tick_en <= clk_5ms & ~c5_q;
        end
    end

    // State, datapath and registered outputs (outputs follow the next state)
    always_ff @(posedge clk_4mhz or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            tick_left <= '0;
            frame_cnt <= '0;
            stop_pend <= 1'b0;
            overrun   <= 1'b0;
            to_cnt    <= '0;
            gate      <= 1'b0;
            rd_req    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            tick_left <= tick_left_n;
            frame_cnt <= frame_cnt_n;
            stop_pend <= stop_pend_n;
            overrun   <= overrun_n;
            to_cnt    <= to_cnt_n;
            gate      <= (state_n == S_ACQ);
            rd_req    <= (state_n == S_READ);
            busy      <= (state_n != S_IDLE);
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_n     = state;
        tick_left_n = tick_left;
        frame_cnt_n = frame_cnt;
        stop_pend_n = stop_pend;
        overrun_n   = overrun;
        to_cnt_n    = to_cnt;

        // A stop while running only takes effect at the end of the current frame
        if ((state != S_IDLE) && stop) begin
            stop_pend_n = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n     = S_ARM;
                    frame_cnt_n = '0;
                    stop_pend_n = 1'b0;
                    overrun_n   = 1'b0;
                end
            end
            S_ARM: begin
                if (tick_en) begin
                    // Zero-length request still produces a one-tick frame
                    tick_left_n = (cfg_ticks == '0) ? PERIOD_W'(1) : cfg_ticks;
                    state_n     = S_ACQ;
                end
            end
            S_ACQ: begin
                if (tick_en) begin
                    if (tick_left == PERIOD_W'(1)) begin
                        state_n     = S_READ;
                        frame_cnt_n = frame_cnt + 16'd1;
                        to_cnt_n    = '0;
                    end else begin
                        tick_left_n = tick_left - PERIOD_W'(1);
                    end
                end
            end
            S_READ: begin
                // An ack coinciding with the final timeout cycle wins over the timeout
                if (rd_ack || (to_cnt == (ACK_TIMEOUT - 16'd1))) begin
                    if (!rd_ack) begin
                        overrun_n = 1'b1;
                    end
                    if (stop_pend || stop) begin
                        state_n     = S_IDLE;
                        stop_pend_n = 1'b0;
                    end else begin
                        state_n = S_ARM;
                    end
                end else begin
                    to_cnt_n = to_cnt + 16'd1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_meas_scheduler.sv
// Directed testbench for meas_scheduler. The timebase and readout timeout
// are scaled down (tick = 20 clocks, timeout = 40 clocks) to keep runs short.
`timescale 1ns/1ps
module tb_meas_scheduler;

    localparam int unsigned PERIOD_W = 8;
    localparam int          TICK_CYC = 20;
    localparam int          TO_CYC   = 40;

    logic                clk_4mhz = 1'b0;
    logic                reset_n  = 1'b0;
    logic                clk_5ms  = 1'b0;
    logic                start    = 1'b0;
    logic                stop     = 1'b0;
    logic [PERIOD_W-1:0] cfg_ticks = '0;
    logic                rd_ack   = 1'b0;
    logic                gate;
    logic                rd_req;
    logic                busy;
    logic [15:0]         frame_cnt;
    logic                overrun;

    int errors = 0;
    int checks = 0;

    int tcnt     = 0;
    int gate_run = 0;
    int gate_len = 0;
    int rd_run   = 0;
    int rd_len   = 0;

    meas_scheduler #(
        .PERIOD_W    (PERIOD_W),
        .ACK_TIMEOUT (16'(TO_CYC))
    ) dut (
        .clk_4mhz  (clk_4mhz),
        .reset_n   (reset_n),
        .clk_5ms   (clk_5ms),
        .start     (start),
        .stop      (stop),
        .cfg_ticks (cfg_ticks),
        .rd_ack    (rd_ack),
        .gate      (gate),
        .rd_req    (rd_req),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .overrun   (overrun)
    );

    always #125 clk_4mhz = ~clk_4mhz;

    // Timebase square wave, synchronous to the system clock
    always @(negedge clk_4mhz) begin
        tcnt    = (tcnt == TICK_CYC - 1) ? 0 : tcnt + 1;
        clk_5ms = (tcnt < TICK_CYC / 2);
    end

    // Measure the high time of gate and rd_req in clock cycles
    always @(posedge clk_4mhz) begin
        #1;
        if (gate) gate_run = gate_run + 1;
        else if (gate_run != 0) begin gate_len = gate_run; gate_run = 0; end
        if (rd_req) rd_run = rd_run + 1;
        else if (rd_run != 0) begin rd_len = rd_run; rd_run = 0; end
    end

    // Bounded wait for an output to reach a level; sel 0=gate 1=rd_req 2=busy
    task automatic wait_sig(input int sel, input logic lvl, input int max_cyc, input string tag);
        logic v;
        bit   hit;
        hit = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk_4mhz);
            v = (sel == 0) ? gate : (sel == 1) ? rd_req : busy;
            if (v === lvl) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) begin
            checks++; errors++;
            $display("FAIL %s: no level %0b within %0d cycles", tag, lvl, max_cyc);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk_4mhz); start = 1'b1;
        @(negedge clk_4mhz); start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk_4mhz); stop = 1'b1;
        @(negedge clk_4mhz); stop = 1'b0;
    endtask

    task automatic pulse_ack();
        @(negedge clk_4mhz); rd_ack = 1'b1;
        @(negedge clk_4mhz); rd_ack = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_4mhz);
        checks++; if (gate !== 1'b0) begin errors++; $display("FAIL reset_gate: got %b want 0", gate); end
        checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req: got %b want 0", rd_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
        reset_n = 1'b1;
        repeat (3 * TICK_CYC) @(negedge clk_4mhz);
        checks++; if (busy !== 1'b0 || gate !== 1'b0) begin errors++; $display("FAIL idle_after_release: busy=%b gate=%b want 0 0", busy, gate); end
    endtask

    task automatic test_basic();
        cfg_ticks = 8'd3;
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
        wait_sig(0, 1'b1, 3 * TICK_CYC, "basic_gate_rise");
        wait_sig(0, 1'b0, 4 * TICK_CYC, "basic_gate_fall");
        checks++; if (gate_len != 3 * TICK_CYC) begin errors++; $display("FAIL basic_gate_len: got %0d want %0d", gate_len, 3 * TICK_CYC); end
        checks++; if (rd_req !== 1'b1) begin errors++; $display("FAIL basic_rd_req: got %b want 1", rd_req); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL basic_frame_cnt: got %0d want 1", frame_cnt); end
        repeat (5) @(negedge clk_4mhz);
        pulse_ack();
        checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL basic_rd_drop: got %b want 0", rd_req); end
        checks++; if (busy !== 1'b1 || gate !== 1'b0) begin errors++; $display("FAIL basic_arm: busy=%b gate=%b want 1 0", busy, gate); end
        wait_sig(0, 1'b1, 3 * TICK_CYC, "basic_next_frame");
    endtask

    task automatic test_stop();
        pulse_stop();
        wait_sig(0, 1'b0, 4 * TICK_CYC, "stop_gate_fall");
        checks++; if (gate_len != 3 * TICK_CYC) begin errors++; $display("FAIL stop_gate_len: got %0d want %0d", gate_len, 3 * TICK_CYC); end
        checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL stop_frame_cnt: got %0d want 2", frame_cnt); end
        pulse_ack();
        checks++; if (busy !== 1'b0 || rd_req !== 1'b0 || gate !== 1'b0) begin
            errors++; $display("FAIL stop_idle: busy=%b rd_req=%b gate=%b want 0 0 0", busy, rd_req, gate);
        end
        repeat (3 * TICK_CYC) @(negedge clk_4mhz);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_stays_idle: got %b want 0", busy); end
    endtask

    task automatic test_timeout();
        cfg_ticks = 8'd2;
        pulse_start();
        wait_sig(0, 1'b1, 3 * TICK_CYC, "to_gate_rise");
        wait_sig(0, 1'b0, 3 * TICK_CYC, "to_gate_fall");
        wait_sig(1, 1'b0, TO_CYC + 10, "to_rd_drop");
        checks++; if (rd_len != TO_CYC) begin errors++; $display("FAIL to_rd_len: got %0d want %0d", rd_len, TO_CYC); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL to_overrun: got %b want 1", overrun); end
        checks++; if (busy !== 1'b1 || frame_cnt !== 16'd1) begin errors++; $display("FAIL to_arm: busy=%b frame_cnt=%0d want 1 1", busy, frame_cnt); end
        wait_sig(0, 1'b1, 3 * TICK_CYC, "to_next_frame");
        pulse_stop();
        wait_sig(0, 1'b0, 3 * TICK_CYC, "to_gate_fall2");
        pulse_ack();
        checks++; if (busy !== 1'b0 || overrun !== 1'b1) begin errors++; $display("FAIL to_sticky: busy=%b overrun=%b want 0 1", busy, overrun); end
    endtask

    task automatic test_zero_and_coincident_ack();
        cfg_ticks = 8'd0;
        pulse_start();
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL zero_overrun_clear: got %b want 0", overrun); end
        wait_sig(0, 1'b1, 3 * TICK_CYC, "zero_gate_rise");
        pulse_stop();
        wait_sig(0, 1'b0, 2 * TICK_CYC, "zero_gate_fall");
        checks++; if (gate_len != TICK_CYC) begin errors++; $display("FAIL zero_gate_len: got %0d want %0d", gate_len, TICK_CYC); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL zero_frame_cnt: got %0d want 1", frame_cnt); end
        // Now in the first READ cycle: hold ack for exactly the last timeout cycle
        repeat (TO_CYC - 1) @(negedge clk_4mhz);
        checks++; if (rd_req !== 1'b1) begin errors++; $display("FAIL coinc_rd_held: got %b want 1", rd_req); end
        rd_ack = 1'b1;
        @(negedge clk_4mhz);
        rd_ack = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL coinc_overrun: got %b want 0", overrun); end
        checks++; if (rd_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL coinc_exit: rd_req=%b busy=%b want 0 0", rd_req, busy); end
    endtask

    task automatic test_start_stop();
        cfg_ticks = 8'd1;
        @(negedge clk_4mhz); start = 1'b1; stop = 1'b1;
        @(negedge clk_4mhz); start = 1'b0; stop = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ss_busy: got %b want 1", busy); end
        wait_sig(0, 1'b1, 3 * TICK_CYC, "ss_gate_rise");
        wait_sig(0, 1'b0, 2 * TICK_CYC, "ss_gate_fall");
        pulse_ack();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ss_no_stop_pend: busy=%b want 1", busy); end
        wait_sig(0, 1'b1, 3 * TICK_CYC, "ss_frame2");
        pulse_start();
        checks++; if (frame_cnt !== 16'd1 || gate !== 1'b1) begin errors++; $display("FAIL ss_start_ignored: frame_cnt=%0d gate=%b want 1 1", frame_cnt, gate); end
        pulse_stop();
        wait_sig(0, 1'b0, 2 * TICK_CYC, "ss_gate_fall2");
        pulse_ack();
        checks++; if (frame_cnt !== 16'd2 || busy !== 1'b0) begin errors++; $display("FAIL ss_end: frame_cnt=%0d busy=%b want 2 0", frame_cnt, busy); end
    endtask

    task automatic test_reset_mid();
        cfg_ticks = 8'd4;
        pulse_start();
        wait_sig(0, 1'b1, 3 * TICK_CYC, "rm_gate_rise");
        wait_sig(0, 1'b0, 5 * TICK_CYC, "rm_gate_fall");
        pulse_ack();
        wait_sig(0, 1'b1, 3 * TICK_CYC, "rm_frame2");
        repeat (10) @(negedge clk_4mhz);
        #10 reset_n = 1'b0;
        #1;
        checks++; if (gate !== 1'b0) begin errors++; $display("FAIL rm_gate_async: got %b want 0", gate); end
        checks++; if (busy !== 1'b0 || frame_cnt !== 16'd0) begin errors++; $display("FAIL rm_state: busy=%b frame_cnt=%0d want 0 0", busy, frame_cnt); end
        repeat (3) @(negedge clk_4mhz);
        reset_n = 1'b1;
        repeat (3 * TICK_CYC) @(negedge clk_4mhz);
        checks++; if (busy !== 1'b0 || gate !== 1'b0 || rd_req !== 1'b0) begin
            errors++; $display("FAIL rm_idle: busy=%b gate=%b rd_req=%b want 0 0 0", busy, gate, rd_req);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stop();
        test_timeout();
        test_zero_and_coincident_ack();
        test_start_stop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
